// File: rtl/subtract_32_bit_pkg.sv
// ============================================================================
//  Module   : subtract_32_bit_pkg
//  Brief    : Shared width, reset value and result record for the SUB path.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package subtract_32_bit_pkg;

    localparam int WIDTH = 32;

    localparam logic [WIDTH-1:0] SUM_RESET = '0;

    typedef struct packed {
        logic             cout;
        logic [WIDTH-1:0] sum;
    } result_t;

endpackage

`default_nettype wire

// File: rtl/subtract_32_bit_adder.sv
// ============================================================================
//  Module   : adder_32_bit
//  Brief    : Combinational a + b + cin built from 4-bit carry-lookahead groups.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_32_bit #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int NGROUPS = WIDTH / 4;

    logic [NGROUPS:0] w_gc;

    assign w_gc[0] = cin_i;

    for (genvar gi = 0; gi < NGROUPS; gi++) begin : g_group
        logic [3:0] w_p;
        logic [3:0] w_g;
        logic [3:0] w_c;

        assign w_p = a_i[4*gi +: 4] ^ b_i[4*gi +: 4];
        assign w_g = a_i[4*gi +: 4] & b_i[4*gi +: 4];

        // Every carry is expanded from the group carry-in, so carries inside a group do not ripple.
        assign w_c[0] = w_gc[gi];
        assign w_c[1] = w_g[0] | (w_p[0] & w_gc[gi]);
        assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_gc[gi]);
        assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                      | (w_p[2] & w_p[1] & w_p[0] & w_gc[gi]);

        assign w_gc[gi+1] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                          | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                          | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_gc[gi]);

        assign sum_o[4*gi +: 4] = w_p ^ w_c;
    end

    assign cout_o = w_gc[NGROUPS];

endmodule

`default_nettype wire

// File: rtl/subtract_32_bit.sv
// ============================================================================
//  Module   : subtract_32_bit
//  Brief    : Registered a - b as a + ~b + 1; cout is the not-borrow flag.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module subtract_32_bit
    import subtract_32_bit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    result_t res_d;
    result_t res_q;

    adder_32_bit #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a_i    (a),
        .b_i    (~b),
        .cin_i  (1'b1),
        .sum_o  (res_d.sum),
        .cout_o (res_d.cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q.sum  <= SUM_RESET;
            res_q.cout <= 1'b0;
        end else begin
            res_q <= res_d;
        end
    end

    assign sum  = res_q.sum;
    assign cout = res_q.cout;

endmodule

`default_nettype wire

// File: tb/tb_subtract_32_bit.sv
// ============================================================================
//  Module   : tb_subtract_32_bit
//  Brief    : Self-checking bench for the registered 32-bit subtractor.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_subtract_32_bit;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        cout;

    int checks;
    int errors;

    logic [31:0] prev_sum;
    logic        prev_cout;
    logic        have_prev;

    typedef struct {
        logic        rst;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    vec_t vecs[12];

    subtract_32_bit dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .sum  (sum),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain modular subtraction and an unsigned compare.
    function automatic logic [32:0] model(input logic [31:0] va, input logic [31:0] vb);
        logic [31:0] d;
        d = va - vb;
        return {(va >= vb), d};
    endfunction

    task automatic check(input string name, input logic [31:0] got_s, input logic got_c,
                         input logic [31:0] exp_s, input logic exp_c);
        checks++;
        if (got_s !== exp_s || got_c !== exp_c) begin
            errors++;
            $display("FAIL %s: got sum=%08h cout=%0b, expected sum=%08h cout=%0b",
                     name, got_s, got_c, exp_s, exp_c);
        end
    endtask

    // Drive operands, confirm outputs hold until the edge, then check the new result.
    task automatic step(input string name, input logic r, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] es, input logic ec);
        rst = r;
        a   = va;
        b   = vb;
        #3;
        if (have_prev)
            check({name, "_hold"}, sum, cout, prev_sum, prev_cout);
        @(posedge clk);
        #1;
        check(name, sum, cout, es, ec);
        prev_sum  = es;
        prev_cout = ec;
        have_prev = 1'b1;
    endtask

    initial begin
        logic [32:0] e;
        logic [31:0] ra;
        logic [31:0] rb;

        checks    = 0;
        errors    = 0;
        have_prev = 1'b0;
        prev_sum  = '0;
        prev_cout = 1'b0;

        vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[1]  = '{1'b0, 32'h0000_0007, 32'h0000_0006, 32'h0000_0001, 1'b1};
        vecs[2]  = '{1'b0, 32'h0000_0020, 32'h0000_0010, 32'h0000_0010, 1'b1};
        vecs[3]  = '{1'b0, 32'h0000_0080, 32'h0000_0040, 32'h0000_0040, 1'b1};
        vecs[4]  = '{1'b0, 32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFF3, 1'b1};
        vecs[5]  = '{1'b0, 32'h0000_0006, 32'h0000_0007, 32'hFFFF_FFFF, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b1};
        vecs[9]  = '{1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b0, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b1};
        vecs[11] = '{1'b0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};

        // Reset for two cycles with live operands, then release.
        step("reset0", 1'b1, 32'd7, 32'd6, 32'h0, 1'b0);
        step("reset1", 1'b1, 32'd7, 32'd6, 32'h0, 1'b0);
        step("release", 1'b0, 32'd7, 32'd6, 32'h1, 1'b1);

        // Back-to-back table vectors, including a one-cycle reset mid-stream.
        for (int i = 0; i < 12; i++)
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].a, vecs[i].b,
                 vecs[i].exp_sum, vecs[i].exp_cout);

        // Random operands with periodic a==b and b==0 corners.
        for (int i = 0; i < 10000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 16 == 3) rb = ra;
            if (i % 16 == 7) rb = 32'h0;
            e = model(ra, rb);
            step($sformatf("rand%0d", i), 1'b0, ra, rb, e[31:0], e[32]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/subtract_32_bit.md
Name: subtract_32_bit

Overview:
- Registered 32-bit two's-complement subtractor: computes a − b as a + ~b + 1.
- Presents the difference on sum and the final carry on cout.
- cout is the carry out of the MSB, i.e. the not-borrow flag: 1 when a ≥ b unsigned.
- Used as the SUB path of the datapath ALU; outputs are registered, one-cycle latency.

Parameters:
- WIDTH, 32, operand/result width in bits; the block is specified and verified at 32 only.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- a  input  32  minuend; two's-complement or unsigned, bit pattern only.
- b  input  32  subtrahend.
- sum  output  32  registered difference (a − b) mod 2^32.
- cout  output  1  registered carry out of a + ~b + 1; 1 = no borrow, 0 = borrow.

Behaviour:
- One clock; all state updates on the rising edge of clk. Reset is synchronous and active-high.
- Reset:
  - rst=1 at a rising edge → sum=0, cout=0 at that edge.
  - Reset has priority over new operands.
  - Reset mid-stream discards the in-flight result.
- Normal operation: at each rising edge with rst=0:
  - sum ← lower 32 bits of a + ~b + 1.
  - cout ← bit 32 of that same 33-bit sum.
- Latency:
  - Operands present before edge N appear on sum/cout after edge N.
  - Throughput is one result per cycle; no handshake, no valid/ready.
  - Outputs hold their value between edges.
- Arithmetic rules:
  - Result wraps modulo 2^32; no saturation.
  - No overflow output. Signed overflow is the caller's concern: (a[31]≠b[31]) && (sum[31]≠a[31]).
  - a == b → sum=0, cout=1.
  - b == 0 → sum=a, cout=1, since ~0+1 carries out.
  - a < b unsigned → cout=0. Example: 6−7 → sum=32'hFFFFFFFF, cout=0.
  - a=32'h00000000, b=32'h80000000 → sum=32'h80000000, cout=0.
- X/undefined inputs are not required to be handled; the outputs simply reflect the inputs.
- The core datapath is purely combinational ripple/CLA logic feeding one register stage; there are no internal state machines.

Decomposition:
- Shared package: WIDTH constant (32) and a reset-value constant for sum (all zeros).
- Sub-module adder_32_bit: combinational a + b + cin → sum, cout.
  - Built from 32 chained full-adder cells, or 4-bit carry-lookahead groups chained by group carry.
- Top-level responsibilities:
  - Inverts b.
  - Ties cin=1.
  - Registers sum/cout under synchronous reset.

Test Plan:
- Reset: rst=1 for 2 cycles with a=7, b=6 applied → sum=0, cout=0. Deassert rst → next edge sum=1, cout=1.
- Basic: a=0,b=0 → sum=0, cout=1. a=7,b=6 → sum=1, cout=1. a=32,b=16 → sum=16, cout=1. a=128,b=64 → sum=64, cout=1.
- Negative operand: a=−7 (32'hFFFFFFF9), b=6 → sum=−13 (32'hFFFFFFF3), cout=1.
- Borrow: a=6, b=7 → sum=−1 (32'hFFFFFFFF), cout=0. a=0, b=32'h80000000 → sum=32'h80000000, cout=0.
- Back-to-back and latency: change operands every cycle across the above vectors → each result appears exactly one edge later. Assert rst for one cycle mid-sequence → outputs 0 that cycle, then results resume from the current operands.
- Random: 10k random a,b pairs checked against a model, sum == (a−b) mod 2^32 and cout == (a ≥ b unsigned), including a==b and b==0 corners.
